// File: rtl/aes_key_loader.sv
`default_nettype none
// ==========================================================================
// aes_key_loader : assembles a 128-bit key from four 32-bit words and gates encryption
// Revision 1.0
// ==========================================================================
module aes_key_loader #(
  parameter int KEY_WIDTH  = 128,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [WORD_WIDTH-1:0] key_word,
  input  logic                  key_word_valid,
  input  logic                  key_word_last,
  output logic                  key_word_ready,
  input  logic                  encrypt_req,
  input  logic                  encrypt_done,
  input  logic                  key_clear,
  input  logic                  key_rdy,
  output logic [3:0][3:0][7:0]  cipher_key,
  output logic                  encrypt_en,
  output logic                  key_loaded,
  output logic                  load_err
);

  if (KEY_WIDTH != 128 || WORD_WIDTH != 32) begin : g_param_check
    $error("aes_key_loader: only KEY_WIDTH=128 and WORD_WIDTH=32 are supported");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           word_cnt_q, word_cnt_d;
  logic [3:0][3:0][7:0] key_q, key_d;
  logic                 encrypt_en_q, encrypt_en_d;
  logic                 key_loaded_q, key_loaded_d;
  logic                 load_err_q, load_err_d;
  logic                 w_xfer;
  logic                 w_unused_key_rdy;

  // Expander status is observed only; it never gates the loader.
  assign w_unused_key_rdy = key_rdy;

  assign key_word_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign w_xfer         = key_word_valid && key_word_ready;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    key_d      = key_q;
    load_err_d = 1'b0;

    if (key_clear) begin
      state_d    = S_IDLE;
      word_cnt_d = 2'd0;
      key_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_xfer) begin
            if (key_word_last) begin
              load_err_d = 1'b1;
            end else begin
              for (int r = 0; r < 4; r++) key_d[r][0] = key_word[8*(3-r) +: 8];
              word_cnt_d = 2'd1;
              state_d    = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            // The last flag must coincide exactly with the fourth word.
            if (key_word_last != (word_cnt_q == 2'd3)) begin
              load_err_d = 1'b1;
              key_d      = '0;
              word_cnt_d = 2'd0;
              state_d    = S_IDLE;
            end else begin
              for (int r = 0; r < 4; r++) key_d[r][word_cnt_q] = key_word[8*(3-r) +: 8];
              if (word_cnt_q == 2'd3) begin
                state_d = S_READY;
              end else begin
                word_cnt_d = word_cnt_q + 2'd1;
              end
            end
          end
        end
        S_READY: begin
          if (encrypt_req) state_d = S_RUN;
        end
        S_RUN: begin
          if (encrypt_done) state_d = S_READY;
        end
        default: begin
          state_d    = S_IDLE;
          word_cnt_d = 2'd0;
          key_d      = '0;
        end
      endcase
    end

    encrypt_en_d = (state_d == S_RUN);
    key_loaded_d = (state_d == S_READY) || (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= 2'd0;
      key_q        <= '0;
      encrypt_en_q <= 1'b0;
      key_loaded_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      key_q        <= key_d;
      encrypt_en_q <= encrypt_en_d;
      key_loaded_q <= key_loaded_d;
      load_err_q   <= load_err_d;
    end
  end

  assign cipher_key = key_q;
  assign encrypt_en = encrypt_en_q;
  assign key_loaded = key_loaded_q;
  assign load_err   = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_loader.sv
`default_nettype none
// ==========================================================================
// tb_aes_key_loader : scenario tasks plus randomized run against a word-queue key model
// Revision 1.0
// ==========================================================================
module tb_aes_key_loader;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b1;
  logic [31:0]          key_word = '0;
  logic                 key_word_valid = 1'b0;
  logic                 key_word_last = 1'b0;
  logic                 key_word_ready;
  logic                 encrypt_req = 1'b0;
  logic                 encrypt_done = 1'b0;
  logic                 key_clear = 1'b0;
  logic                 key_rdy = 1'b0;
  logic [3:0][3:0][7:0] cipher_key;
  logic                 encrypt_en;
  logic                 key_loaded;
  logic                 load_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the key is whatever words have been accepted so far.
  logic [31:0]          m_q[$];
  logic [3:0][3:0][7:0] m_key = '0;
  logic                 m_loaded = 1'b0;
  logic                 m_run = 1'b0;
  logic                 m_err = 1'b0;

  aes_key_loader #(.KEY_WIDTH(128), .WORD_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .key_word(key_word), .key_word_valid(key_word_valid),
    .key_word_last(key_word_last), .key_word_ready(key_word_ready),
    .encrypt_req(encrypt_req), .encrypt_done(encrypt_done), .key_clear(key_clear),
    .key_rdy(key_rdy), .cipher_key(cipher_key), .encrypt_en(encrypt_en),
    .key_loaded(key_loaded), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int n;
    n     = m_q.size();
    m_err = 1'b0;
    if (resetn || key_clear) begin
      m_q.delete(); m_key = '0; m_loaded = 1'b0; m_run = 1'b0;
    end else if (!m_loaded) begin
      if (key_word_valid) begin
        if (key_word_last != (n == 3)) begin
          m_err = 1'b1;
          m_q.delete();
          m_key = '0;
        end else begin
          m_q.push_back(key_word);
          for (int r = 0; r < 4; r++) m_key[r][n] = key_word[31-8*r -: 8];
          if (n == 3) m_loaded = 1'b1;
        end
      end
    end else if (!m_run) begin
      if (encrypt_req) m_run = 1'b1;
    end else if (encrypt_done) begin
      m_run = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    resetn = 1'b0; key_word_valid = 1'b0; key_word_last = 1'b0;
    encrypt_req = 1'b0; encrypt_done = 1'b0; key_clear = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    key_word = w; key_word_valid = 1'b1; key_word_last = last;
    tick();
    key_word_valid = 1'b0; key_word_last = 1'b0;
  endtask

  task automatic load_random_key();
    for (int i = 0; i < 4; i++) send($urandom, i == 3);
  endtask

  task automatic test_reset();
    resetn = 1'b1; tick(); tick(); quiet();
    n_cmp += 5;
    if (cipher_key !== '0) begin n_bad++; $display("FAIL reset_key: got %h want 0", cipher_key); end
    if (encrypt_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", encrypt_en); end
    if (key_loaded !== 1'b0) begin n_bad++; $display("FAIL reset_loaded: got %b want 0", key_loaded); end
    if (load_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", load_err); end
    if (key_word_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", key_word_ready); end
  endtask

  task automatic test_vector_load();
    logic [31:0] vec [4];
    vec[0] = 32'h2B7E1516; vec[1] = 32'h28AED2A6; vec[2] = 32'hABF71588; vec[3] = 32'h09CF4F3C;
    for (int i = 0; i < 3; i++) send(vec[i], 1'b0);
    n_cmp += 1;
    if (key_loaded !== 1'b0) begin n_bad++; $display("FAIL vec_early_loaded: got %b want 0", key_loaded); end
    send(vec[3], 1'b1);
    n_cmp += 7;
    if (key_loaded !== 1'b1) begin n_bad++; $display("FAIL vec_loaded: got %b want 1", key_loaded); end
    if (cipher_key[0][0] !== 8'h2B) begin n_bad++; $display("FAIL vec_k00: got %h want 2b", cipher_key[0][0]); end
    if (cipher_key[3][0] !== 8'h16) begin n_bad++; $display("FAIL vec_k30: got %h want 16", cipher_key[3][0]); end
    if (cipher_key[0][3] !== 8'h09) begin n_bad++; $display("FAIL vec_k03: got %h want 09", cipher_key[0][3]); end
    if (cipher_key[3][3] !== 8'h3C) begin n_bad++; $display("FAIL vec_k33: got %h want 3c", cipher_key[3][3]); end
    if (cipher_key !== m_key) begin n_bad++; $display("FAIL vec_key: got %h want %h", cipher_key, m_key); end
    if (key_word_ready !== 1'b0) begin n_bad++; $display("FAIL vec_ready: got %b want 0", key_word_ready); end
    send($urandom, 1'b1);
    n_cmp += 1;
    if (cipher_key !== m_key) begin n_bad++; $display("FAIL vec_hold: got %h want %h", cipher_key, m_key); end
  endtask

  task automatic test_encrypt_cycle();
    logic [3:0][3:0][7:0] held;
    held = m_key;
    for (int pass = 0; pass < 2; pass++) begin
      encrypt_req = 1'b1; tick(); encrypt_req = 1'b0;
      for (int c = 0; c < 12; c++) begin
        n_cmp += 2;
        if (encrypt_en !== 1'b1) begin n_bad++; $display("FAIL run_en p%0d c%0d: got %b want 1", pass, c, encrypt_en); end
        if (cipher_key !== held) begin n_bad++; $display("FAIL run_key p%0d c%0d: got %h want %h", pass, c, cipher_key, held); end
        tick();
      end
      encrypt_done = 1'b1; tick(); encrypt_done = 1'b0;
      n_cmp += 3;
      if (encrypt_en !== 1'b0) begin n_bad++; $display("FAIL done_en p%0d: got %b want 0", pass, encrypt_en); end
      if (key_loaded !== 1'b1) begin n_bad++; $display("FAIL done_loaded p%0d: got %b want 1", pass, key_loaded); end
      if (cipher_key !== held) begin n_bad++; $display("FAIL done_key p%0d: got %h want %h", pass, cipher_key, held); end
    end
    encrypt_done = 1'b1; tick(); encrypt_done = 1'b0;
    n_cmp += 1;
    if (encrypt_en !== 1'b0) begin n_bad++; $display("FAIL done_in_ready: got %b want 0", encrypt_en); end
  endtask

  task automatic test_bad_last_early();
    key_clear = 1'b1; tick(); key_clear = 1'b0;
    send($urandom, 1'b0);
    send($urandom, 1'b1);
    n_cmp += 3;
    if (load_err !== 1'b1) begin n_bad++; $display("FAIL early_err: got %b want 1", load_err); end
    if (cipher_key !== '0) begin n_bad++; $display("FAIL early_key: got %h want 0", cipher_key); end
    if (key_word_ready !== 1'b1) begin n_bad++; $display("FAIL early_ready: got %b want 1", key_word_ready); end
    tick();
    n_cmp += 1;
    if (load_err !== 1'b0) begin n_bad++; $display("FAIL early_err_pulse: got %b want 0", load_err); end
    load_random_key();
    n_cmp += 2;
    if (key_loaded !== 1'b1) begin n_bad++; $display("FAIL early_reload: got %b want 1", key_loaded); end
    if (cipher_key !== m_key) begin n_bad++; $display("FAIL early_reload_key: got %h want %h", cipher_key, m_key); end
  endtask

  task automatic test_missing_last();
    key_clear = 1'b1; tick(); key_clear = 1'b0;
    for (int i = 0; i < 4; i++) send($urandom, 1'b0);
    n_cmp += 3;
    if (load_err !== 1'b1) begin n_bad++; $display("FAIL nolast_err: got %b want 1", load_err); end
    if (key_loaded !== 1'b0) begin n_bad++; $display("FAIL nolast_loaded: got %b want 0", key_loaded); end
    if (cipher_key !== '0) begin n_bad++; $display("FAIL nolast_key: got %h want 0", cipher_key); end
    send(32'hFFFF_FFFF, 1'b1);
    n_cmp += 3;
    if (load_err !== 1'b1) begin n_bad++; $display("FAIL first_last_err: got %b want 1", load_err); end
    if (cipher_key !== '0) begin n_bad++; $display("FAIL first_last_key: got %h want 0", cipher_key); end
    if (key_loaded !== 1'b0) begin n_bad++; $display("FAIL first_last_loaded: got %b want 0", key_loaded); end
    tick();
    n_cmp += 1;
    if (load_err !== 1'b0) begin n_bad++; $display("FAIL first_last_pulse: got %b want 0", load_err); end
  endtask

  task automatic test_clear();
    load_random_key();
    encrypt_req = 1'b1; tick(); encrypt_req = 1'b0;
    tick();
    key_clear = 1'b1; encrypt_done = 1'b1; tick(); quiet();
    n_cmp += 5;
    if (encrypt_en !== 1'b0) begin n_bad++; $display("FAIL clr_run_en: got %b want 0", encrypt_en); end
    if (key_loaded !== 1'b0) begin n_bad++; $display("FAIL clr_run_loaded: got %b want 0", key_loaded); end
    if (cipher_key !== '0) begin n_bad++; $display("FAIL clr_run_key: got %h want 0", cipher_key); end
    if (key_word_ready !== 1'b1) begin n_bad++; $display("FAIL clr_run_ready: got %b want 1", key_word_ready); end
    if (load_err !== 1'b0) begin n_bad++; $display("FAIL clr_run_err: got %b want 0", load_err); end
    send($urandom, 1'b0);
    send($urandom, 1'b0);
    key_clear = 1'b1; send(32'hDEAD_BEEF, 1'b0); key_clear = 1'b0;
    n_cmp += 2;
    if (cipher_key !== '0) begin n_bad++; $display("FAIL clr_load_key: got %h want 0", cipher_key); end
    if (load_err !== 1'b0) begin n_bad++; $display("FAIL clr_load_err: got %b want 0", load_err); end
    load_random_key();
    n_cmp += 2;
    if (key_loaded !== 1'b1) begin n_bad++; $display("FAIL clr_reload: got %b want 1", key_loaded); end
    if (cipher_key !== m_key) begin n_bad++; $display("FAIL clr_reload_key: got %h want %h", cipher_key, m_key); end
  endtask

  task automatic test_reset_mid();
    key_clear = 1'b1; tick(); key_clear = 1'b0;
    send($urandom, 1'b0);
    send($urandom, 1'b0);
    resetn = 1'b1; send($urandom, 1'b0); resetn = 1'b0;
    n_cmp += 3;
    if (cipher_key !== '0) begin n_bad++; $display("FAIL rst_load_key: got %h want 0", cipher_key); end
    if (key_loaded !== 1'b0) begin n_bad++; $display("FAIL rst_load_loaded: got %b want 0", key_loaded); end
    if (key_word_ready !== 1'b1) begin n_bad++; $display("FAIL rst_load_ready: got %b want 1", key_word_ready); end
    load_random_key();
    encrypt_req = 1'b1; tick(); encrypt_req = 1'b0;
    resetn = 1'b1; tick(); resetn = 1'b0;
    n_cmp += 3;
    if (encrypt_en !== 1'b0) begin n_bad++; $display("FAIL rst_run_en: got %b want 0", encrypt_en); end
    if (key_loaded !== 1'b0) begin n_bad++; $display("FAIL rst_run_loaded: got %b want 0", key_loaded); end
    if (cipher_key !== '0) begin n_bad++; $display("FAIL rst_run_key: got %h want 0", cipher_key); end
    encrypt_req = 1'b1; tick(); tick(); encrypt_req = 1'b0;
    n_cmp += 1;
    if (encrypt_en !== 1'b0) begin n_bad++; $display("FAIL req_unloaded_en: got %b want 0", encrypt_en); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      resetn         = ($urandom_range(0, 99) == 0);
      key_clear      = ($urandom_range(0, 39) == 0);
      key_word       = $urandom;
      key_word_valid = $urandom_range(0, 1);
      key_word_last  = (m_q.size() == 3) ^ ($urandom_range(0, 7) == 0);
      encrypt_req    = ($urandom_range(0, 3) == 0);
      encrypt_done   = ($urandom_range(0, 7) == 0);
      key_rdy        = $urandom_range(0, 1);
      tick();
      n_cmp += 5;
      if (cipher_key !== m_key) begin n_bad++; $display("FAIL rnd_key c%0d: got %h want %h", c, cipher_key, m_key); end
      if (key_loaded !== m_loaded) begin n_bad++; $display("FAIL rnd_loaded c%0d: got %b want %b", c, key_loaded, m_loaded); end
      if (encrypt_en !== m_run) begin n_bad++; $display("FAIL rnd_en c%0d: got %b want %b", c, encrypt_en, m_run); end
      if (load_err !== m_err) begin n_bad++; $display("FAIL rnd_err c%0d: got %b want %b", c, load_err, m_err); end
      if (key_word_ready !== !m_loaded) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, key_word_ready, !m_loaded); end
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_vector_load();
    test_encrypt_cycle();
    test_bad_last_early();
    test_missing_last();
    test_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
